uart_move_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sample_tick.sv | 32 +++
 rtl/uart_move_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_move_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the move-link UART: receiver state encoding and vote positions.
package uart_pkg;

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int VOTE_P0 = 7;
    localparam int VOTE_P1 = 8;
    localparam int VOTE_P2 = 9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sample_tick.sv
// Free-running CLK_PER_SAMP divider with synchronous clear; emits a one-cycle tick.
module uart_sample_tick #(
    parameter int CLK_PER_SAMP = 423
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_SAMP - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST) && !clear;
        cnt_d = cnt_q + 1'b1;
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_move_rx.sv
// 8N1 receiver for the board-to-board move link: 16x oversampling, 2-of-3 voting,
// start-glitch rejection, stop-bit framing check and idle qualification after reset.
module uart_move_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ        = 65_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int SAMP_PER_BIT  = 16,
    parameter int CLK_PER_SAMP  = 423,
    parameter int PKT_LEN       = 8,
    parameter int WAITING_COUNT = 65_000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rx,
    output logic               ready,
    output logic [PKT_LEN-1:0] data_out,
    output logic               frame_err,
    output logic               busy
);

    localparam int SIDX_W = $clog2((PKT_LEN + 2) * SAMP_PER_BIT);
    localparam int WAIT_W = $clog2(WAITING_COUNT + 1);

    if (SAMP_PER_BIT < 12 || CLK_HZ <= 0 || BAUD_RATE <= 0) begin : g_bad_cfg
        $error("uart_move_rx: invalid oversampling or clock configuration");
    end

    logic               sync1_q, sync1_d;
    logic               rx_s_q, rx_s_d;
    logic               rx_prev_q, rx_prev_d;
    rx_state_t          state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [SIDX_W-1:0]  sidx_q, sidx_d;
    logic               v0_q, v0_d;
    logic               v1_q, v1_d;
    logic [PKT_LEN-1:0] shift_q, shift_d;
    logic [PKT_LEN-1:0] data_q, data_d;
    logic               ready_q, ready_d;
    logic               ferr_q, ferr_d;
    logic               busy_q, busy_d;

    logic        tick;
    logic        clear;
    logic        fall;
    logic        vote;
    logic        decide;
    logic [31:0] p_val;
    logic [31:0] b_val;

    uart_sample_tick #(
        .CLK_PER_SAMP(CLK_PER_SAMP)
    ) u_tick (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .clear (clear),
        .tick  (tick)
    );

    always_comb begin
        sync1_d   = rx;
        rx_s_d    = sync1_q;
        rx_prev_d = rx_s_q;
        state_d   = state_q;
        wait_d    = wait_q;
        sidx_d    = sidx_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;
        clear     = 1'b0;

        fall   = rx_prev_q & ~rx_s_q;
        vote   = majority3(v0_q, v1_q, rx_s_q);
        p_val  = 32'(sidx_q) % SAMP_PER_BIT;
        b_val  = 32'(sidx_q) / SAMP_PER_BIT;
        decide = tick && (p_val == VOTE_P2);

        if (tick && state_q inside {START, DATA, STOP}) begin
            sidx_d = sidx_q + 1'b1;
            if (p_val == VOTE_P0) v0_d = rx_s_q;
            if (p_val == VOTE_P1) v1_d = rx_s_q;
        end

        case (state_q)
            ARM: begin
                wait_d = rx_s_q ? wait_q + 1'b1 : '0;
                if (rx_s_q && wait_q == WAIT_W'(WAITING_COUNT - 1)) begin
                    wait_d  = '0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (fall) begin
                    clear   = 1'b1;
                    sidx_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (decide) begin
                    state_d = vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[PKT_LEN-1:1]};
                    if (b_val == PKT_LEN) state_d = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (vote) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = ARM;
        endcase

        busy_d = state_d inside {START, DATA, STOP};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: synchronizer resets to the idle-high level so reset release never looks like a start edge.
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ARM;
            wait_q    <= '0;
            sidx_q    <= '0;
            v0_q      <= 1'b1;
            v1_q      <= 1'b1;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            wait_q    <= wait_d;
            sidx_q    <= sidx_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign ready     = ready_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_uart_move_rx.sv
// Directed bench for uart_move_rx with a short divider (4 clocks/sample, 64 clocks/bit).
module tb_uart_move_rx;

    localparam int CPS      = 4;
    localparam int WAITC    = 20;
    localparam int BIT_CLKS = 16 * CPS;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       rx     = 1'b1;
    logic       ready;
    logic [7:0] data_out;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int ready_cyc = 0;
    int n_ready = 0;
    int n_ferr = 0;
    int n_both = 0;
    int n_busy_cyc = 0;
    int n_data_glitch = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] ready_log[$];

    uart_move_rx #(
        .CLK_HZ       (65_000_000),
        .BAUD_RATE    (9600),
        .SAMP_PER_BIT (16),
        .CLK_PER_SAMP (CPS),
        .PKT_LEN      (8),
        .WAITING_COUNT(WAITC)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rx       (rx),
        .ready    (ready),
        .data_out (data_out),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (ready) begin
            n_ready   <= n_ready + 1;
            ready_cyc <= cyc;
            ready_log.push_back(data_out);
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (ready && frame_err) n_both <= n_both + 1;
        if (busy) n_busy_cyc <= n_busy_cyc + 1;
        if (!rst_in && !ready && data_out !== prev_data) n_data_glitch <= n_data_glitch + 1;
        prev_data <= data_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        clocks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk_in);
        #1;
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0, b0, base;

        // Reset state
        rx = 1'b1;
        rst_in = 1'b1;
        clocks(3);
        rst_in = 1'b0;
        check("rst ready", ready, 0);
        check("rst frame_err", frame_err, 0);
        check("rst busy", busy, 0);
        check("rst data_out", data_out, 8'h00);

        // Arm, then a clean frame with latency measurement
        clocks(WAITC);
        send_frame(8'hA5, 1'b1);
        clocks(5);
        check("a5 ready count", n_ready, 1);
        check("a5 data_out", data_out, 8'hA5);
        check("a5 frame_err count", n_ferr, 0);
        check("a5 latency", ready_cyc - fall_cyc, 619);

        // Bad stop bit
        r0 = n_ready; f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        clocks(5);
        check("ferr pulse count", n_ferr - f0, 1);
        check("ferr no ready", n_ready - r0, 0);
        check("ferr data held", data_out, 8'hA5);

        // Start-bit glitch of 12 clocks
        r0 = n_ready; f0 = n_ferr;
        @(posedge clk_in);
        #1;
        rx = 1'b0;
        clocks(6);
        check("glitch busy high", busy, 1);
        clocks(6);
        rx = 1'b1;
        clocks(60);
        check("glitch busy low", busy, 0);
        check("glitch no ready", n_ready - r0, 0);
        check("glitch no ferr", n_ferr - f0, 0);

        // Back-to-back frames
        r0 = n_ready;
        base = ready_log.size();
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        clocks(5);
        check("b2b ready count", n_ready - r0, 2);
        if (ready_log.size() >= base + 2) begin
            check("b2b first byte", ready_log[base], 8'h12);
            check("b2b second byte", ready_log[base+1], 8'h34);
        end else begin
            check("b2b log size", ready_log.size(), base + 2);
        end
        check("b2b data_out", data_out, 8'h34);

        // Reset during bit 4 of a frame
        @(posedge clk_in);
        #1;
        drive_bit(1'b0);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        rx = 1'b0;
        clocks(30);
        rst_in = 1'b1;
        rx = 1'b1;
        clocks(3);
        rst_in = 1'b0;
        check("abort busy", busy, 0);
        check("abort data_out", data_out, 8'h00);
        r0 = n_ready; f0 = n_ferr;
        clocks(WAITC);
        send_frame(8'h7E, 1'b1);
        clocks(5);
        check("abort ready count", n_ready - r0, 1);
        check("abort ferr count", n_ferr - f0, 0);
        check("abort data", data_out, 8'h7E);

        // Low line through reset, short high, drop, then proper arming
        rst_in = 1'b1;
        rx = 1'b0;
        clocks(3);
        rst_in = 1'b0;
        r0 = n_ready; f0 = n_ferr; b0 = n_busy_cyc;
        rx = 1'b1;
        clocks(10);
        rx = 1'b0;
        clocks(5);
        rx = 1'b1;
        clocks(WAITC);
        check("arm no busy", n_busy_cyc - b0, 0);
        check("arm no ready", n_ready - r0, 0);
        check("arm no ferr", n_ferr - f0, 0);
        send_frame(8'h01, 1'b1);
        clocks(5);
        check("arm ready count", n_ready - r0, 1);
        check("arm data", data_out, 8'h01);

        // Global invariants
        check("ready/ferr overlap", n_both, 0);
        check("data_out change without ready", n_data_glitch, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
